axis_xform_pipe: RTL and testbench
==================================

AXIS_XFORM_PIPE -- requirements
Module: axis_xform_pipe

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the tdata width in bits; it must be a multiple of 8 and at least 8.
REQ-002 The block SHALL have parameter CNT_WIDTH, default 16, giving the width of the statistics counters.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 The block SHALL have the following ports, in this order:
 - aclk  in  1  clock.
 - aresetn  in  1  asynchronous active-low reset.
 - s_axis_tdata  in  DATA_WIDTH  input beat data.
 - s_axis_tvalid  in  1  input beat valid.
 - s_axis_tready  out  1  block can accept an input beat.
 - s_axis_tlast  in  1  last beat of a packet.
 - s_axis_tkeep  in  DATA_WIDTH/8  byte keep.
 - s_axis_tstrb  in  DATA_WIDTH/8  byte strobe.
 - m_axis_tdata  out  DATA_WIDTH  output beat data.
 - m_axis_tvalid  out  1  output beat valid.
 - m_axis_tready  in  1  downstream can accept a beat.
 - m_axis_tlast  out  1  last beat of a packet.
 - m_axis_tkeep  out  DATA_WIDTH/8  byte keep.
 - m_axis_tstrb  out  DATA_WIDTH/8  byte strobe.
 - mode  in  2  transform select: 0 pass, 1 byte-reverse, 2 add, 3 xor.
 - add_value  in  DATA_WIDTH  addend for mode 2.
 - xor_key  in  DATA_WIDTH  key for mode 3.
 - pkt_count  out  CNT_WIDTH  packets output (stats build only).
 - beat_count  out  CNT_WIDTH  beats output (stats build only).

Function
REQ-005 A beat SHALL transfer on an interface only when valid and ready are both high at a rising edge of aclk.
REQ-006 The transform SHALL depend on the mode in force for the beat:
 - mode 0: data, keep and strb pass through unchanged.
 - mode 1: byte i maps to byte N-1-i, where N = DATA_WIDTH/8; keep and strb are reversed the same way.
 - mode 2: data plus add_value, modulo 2^DATA_WIDTH, with the carry discarded.
 - mode 3: data XOR xor_key.
 - tlast always passes through unchanged.
REQ-007 Modes 2 and 3 SHALL apply to the whole word regardless of tkeep.
REQ-008 mode, add_value and xor_key SHALL be captured on the first accepted beat of a packet and held until the tlast beat is accepted; changes mid-packet have no effect on that packet.
REQ-009 The control FSM SHALL have two states, IDLE and IN_PKT:
 - IDLE to IN_PKT on an accepted beat with tlast=0.
 - IDLE stays IDLE on an accepted beat with tlast=1 (single-beat packet); that beat uses the live mode.
 - IN_PKT to IDLE on an accepted tlast beat.
REQ-010 In IDLE the live mode, add_value and xor_key SHALL be used; in IN_PKT the captured values SHALL be used.
REQ-011 An accepted input beat SHALL appear on m_axis one cycle later: m_axis_tvalid is high at the first edge after acceptance.
REQ-012 All m_axis outputs SHALL be driven from registers.
REQ-013 A two-entry skid buffer SHALL sit on the output, and s_axis_tready SHALL be a registered signal that is low exactly when both entries are occupied.
REQ-014 With m_axis_tready held high the block SHALL sustain one beat per cycle with no bubbles.
REQ-015 Beats SHALL leave in order; none is dropped or duplicated under any pattern of m_axis_tready.
REQ-016 While m_axis_tvalid is high and m_axis_tready is low, all m_axis outputs SHALL hold stable.
REQ-017 When s_axis_tvalid is low no beat SHALL be created, and m_axis_tvalid falls once the buffer drains.
REQ-018 When an input and an output transfer happen in the same cycle, buffer occupancy SHALL stay unchanged.

Reset
REQ-019 While aresetn is low the following SHALL be 0: m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tstrb, m_axis_tlast, s_axis_tready, pkt_count and beat_count; the FSM SHALL be in IDLE.
REQ-020 s_axis_tready SHALL rise at the first rising edge of aclk after aresetn goes high.
REQ-021 A reset asserted mid-packet SHALL discard buffered beats and captured mode; the next accepted beat is treated as the start of a packet.

Configuration
REQ-022 The macro AXIS_XFORM_STATS_EN SHALL control the statistics counters:
 - Defined: beat_count increments on every m_axis transfer; pkt_count increments on every m_axis transfer with tlast=1.
 - Defined: both counters saturate at 2^CNT_WIDTH-1 and do not wrap.
 - Not defined: both ports are tied to 0 and no counter logic is built.

Structure
REQ-023 Package axis_xform_pkg SHALL hold the mode enum (MODE_PASS, MODE_REV, MODE_ADD, MODE_XOR), the FSM state enum, and the byte-reverse function.
REQ-024 The skid buffer SHALL be a sub-module named axis_skid_buf, parameterised by payload width.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
 - Mode 0 with 0xAABBCCDD, tlast=1 -> output 0xAABBCCDD one cycle later, tlast=1.
 - Mode 1 with 0x12345678, keep 0x1 -> output 0x78563412, keep 0x8.
 - Mode 2 with add_value 0x1, data 0xFFFFFFFF -> output 0x00000000 (wrap, carry discarded).
 - A 3-beat packet in mode 3 with xor_key 0xFFFF0000, mode switched to 0 after beat 1 -> all 3 beats XORed; the next packet passes through unchanged.
 - m_axis_tready low for 20 cycles while 4 beats are offered -> s_axis_tready falls after 2 beats are accepted, outputs hold stable, and all 4 beats leave in order once ready returns.
 - Stats build, 5 packets of 2 beats each -> pkt_count=5, beat_count=10; aresetn pulsed low mid-packet -> all outputs 0 and s_axis_tready rises one edge after release.

Source files
------------

// File: rtl/axis_xform_pkg.sv
// rtl/axis_xform_pkg.sv - shared mode/state types and lane-reverse helpers for axis_xform_pipe
package axis_xform_pkg;

  // Widest tdata the reverse helpers handle; DATA_WIDTH must not exceed it.
  localparam int MAX_W = 512;

  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_REV  = 2'd1,
    MODE_ADD  = 2'd2,
    MODE_XOR  = 2'd3
  } mode_e;

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } state_e;

  // Reverse the order of n_lanes lanes of lane_w bits held in the low bits of d.
  function automatic logic [MAX_W-1:0] lane_rev(input logic [MAX_W-1:0] d,
                                                input int n_lanes,
                                                input int lane_w);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < n_lanes * lane_w) begin
        r[(n_lanes - 1 - i / lane_w) * lane_w + i % lane_w] = d[i];
      end
    end
    return r;
  endfunction

  function automatic logic [MAX_W-1:0] byte_rev(input logic [MAX_W-1:0] d,
                                                input int n_bytes);
    return lane_rev(d, n_bytes, 8);
  endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// rtl/axis_skid_buf.sv - two-entry registered skid buffer; head entry drives the output directly
module axis_skid_buf
  import axis_xform_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] s_data_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  output logic [WIDTH-1:0] m_data_o,
  output logic             m_valid_o,
  input  logic             m_ready_i
);

  logic [1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic             valid_q;
  logic             ready_q;
  logic             push;
  logic             pop;

  assign push = s_valid_i && ready_q;
  assign pop  = valid_q && m_ready_i;

  always_comb begin
    cnt_d  = cnt_q;
    head_d = head_q;
    tail_d = tail_q;
    case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) begin
          head_d = s_data_i;
        end else begin
          tail_d = s_data_i;
        end
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        // Occupancy unchanged: the newest beat replaces whichever entry just left.
        if (cnt_q == 2'd2) begin
          head_d = tail_q;
          tail_d = s_data_i;
        end else begin
          head_d = s_data_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      valid_q <= (cnt_d != 2'd0);
      ready_q <= (cnt_d != 2'd2);
    end
  end

  assign s_ready_o = ready_q;
  assign m_data_o  = head_q;
  assign m_valid_o = valid_q;

endmodule

// File: rtl/axis_xform_pipe.sv
// rtl/axis_xform_pipe.sv - AXI-Stream per-packet data transform with registered skid output
// Statistics counters are built only when AXIS_XFORM_STATS_EN is defined.
module axis_xform_pipe
  import axis_xform_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tstrb,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic [DATA_WIDTH/8-1:0] m_axis_tstrb,
  input  logic [1:0]              mode,
  input  logic [DATA_WIDTH-1:0]   add_value,
  input  logic [DATA_WIDTH-1:0]   xor_key,
  output logic [CNT_WIDTH-1:0]    pkt_count,
  output logic [CNT_WIDTH-1:0]    beat_count
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int PW = DATA_WIDTH + 2 * NB + 1;

  state_e                state_q;
  mode_e                 mode_q;
  logic [DATA_WIDTH-1:0] add_q;
  logic [DATA_WIDTH-1:0] xor_q;

  mode_e                 mode_eff;
  logic [DATA_WIDTH-1:0] add_eff;
  logic [DATA_WIDTH-1:0] xor_eff;
  logic                  accept;

  logic [DATA_WIDTH-1:0] x_data;
  logic [NB-1:0]         x_keep;
  logic [NB-1:0]         x_strb;
  logic [PW-1:0]         m_payload;

  assign accept = s_axis_tvalid && s_axis_tready;

  // Packet FSM; the first accepted beat of a multi-beat packet freezes the controls.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      mode_q  <= MODE_PASS;
      add_q   <= '0;
      xor_q   <= '0;
    end else if (accept) begin
      case (state_q)
        IDLE: begin
          if (!s_axis_tlast) begin
            state_q <= IN_PKT;
            mode_q  <= mode_e'(mode);
            add_q   <= add_value;
            xor_q   <= xor_key;
          end
        end
        IN_PKT: begin
          if (s_axis_tlast) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    mode_eff = mode_e'(mode);
    add_eff  = add_value;
    xor_eff  = xor_key;
    if (state_q == IN_PKT) begin
      mode_eff = mode_q;
      add_eff  = add_q;
      xor_eff  = xor_q;
    end
  end

  always_comb begin
    x_data = s_axis_tdata;
    x_keep = s_axis_tkeep;
    x_strb = s_axis_tstrb;
    case (mode_eff)
      MODE_REV: begin
        x_data = DATA_WIDTH'(byte_rev(MAX_W'(s_axis_tdata), NB));
        x_keep = NB'(lane_rev(MAX_W'(s_axis_tkeep), NB, 1));
        x_strb = NB'(lane_rev(MAX_W'(s_axis_tstrb), NB, 1));
      end
      MODE_ADD: x_data = s_axis_tdata + add_eff;
      MODE_XOR: x_data = s_axis_tdata ^ xor_eff;
      default: ;
    endcase
  end

  axis_skid_buf #(
    .WIDTH(PW)
  ) u_skid (
    .clk_i    (aclk),
    .rst_ni   (aresetn),
    .s_data_i ({s_axis_tlast, x_keep, x_strb, x_data}),
    .s_valid_i(s_axis_tvalid),
    .s_ready_o(s_axis_tready),
    .m_data_o (m_payload),
    .m_valid_o(m_axis_tvalid),
    .m_ready_i(m_axis_tready)
  );

  assign {m_axis_tlast, m_axis_tkeep, m_axis_tstrb, m_axis_tdata} = m_payload;

`ifdef AXIS_XFORM_STATS_EN
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [CNT_WIDTH-1:0] pkt_q;
  logic [CNT_WIDTH-1:0] beat_q;
  logic                 m_xfer;

  assign m_xfer = m_axis_tvalid && m_axis_tready;

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pkt_q  <= '0;
      beat_q <= '0;
    end else if (m_xfer) begin
      if (beat_q != CNT_MAX) begin
        beat_q <= beat_q + CNT_WIDTH'(1);
      end
      if (m_axis_tlast && (pkt_q != CNT_MAX)) begin
        pkt_q <= pkt_q + CNT_WIDTH'(1);
      end
    end
  end

  assign pkt_count  = pkt_q;
  assign beat_count = beat_q;
`else
  assign pkt_count  = '0;
  assign beat_count = '0;
`endif

endmodule

// File: tb/tb_axis_xform_pipe.sv
// tb/tb_axis_xform_pipe.sv - scoreboard bench for axis_xform_pipe with a packet-level reference model
module tb_axis_xform_pipe;

  localparam int DW = 32;
  localparam int NB = DW / 8;
  localparam int CW = 16;

  typedef struct packed {
    logic          last;
    logic [NB-1:0] keep;
    logic [NB-1:0] strb;
    logic [DW-1:0] data;
  } beat_t;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic          s_axis_tlast = 1'b0;
  logic [NB-1:0] s_axis_tkeep = '0;
  logic [NB-1:0] s_axis_tstrb = '0;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic          m_axis_tlast;
  logic [NB-1:0] m_axis_tkeep;
  logic [NB-1:0] m_axis_tstrb;
  logic [1:0]    mode = 2'd0;
  logic [DW-1:0] add_value = '0;
  logic [DW-1:0] xor_key = '0;
  logic [CW-1:0] pkt_count;
  logic [CW-1:0] beat_count;

  axis_xform_pipe #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tkeep(s_axis_tkeep), .s_axis_tstrb(s_axis_tstrb),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tkeep(m_axis_tkeep), .m_axis_tstrb(m_axis_tstrb),
    .mode(mode), .add_value(add_value), .xor_key(xor_key),
    .pkt_count(pkt_count), .beat_count(beat_count)
  );

  always #5 aclk = ~aclk;

  int    checks = 0;
  int    errors = 0;
  beat_t exp_q[$];
  int    acc_count = 0;
  bit    ref_in_pkt = 1'b0;
  logic [1:0]    ref_mode;
  logic [DW-1:0] ref_add;
  logic [DW-1:0] ref_xor;
  bit    stall_prev = 1'b0;
  beat_t stall_beat;
  bit    rand_done = 1'b0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference transform, written from the mode definitions on whole bytes.
  function automatic beat_t ref_xform(input beat_t b, input logic [1:0] md,
                                      input logic [DW-1:0] av, input logic [DW-1:0] xk);
    beat_t o;
    o = b;
    case (md)
      2'd1: begin
        for (int i = 0; i < NB; i++) begin
          o.data[8*(NB-1-i) +: 8] = b.data[8*i +: 8];
          o.keep[NB-1-i]          = b.keep[i];
          o.strb[NB-1-i]          = b.strb[i];
        end
      end
      2'd2: o.data = b.data + av;
      2'd3: o.data = b.data ^ xk;
      default: ;
    endcase
    return o;
  endfunction

  always @(negedge aresetn) begin
    exp_q.delete();
    ref_in_pkt = 1'b0;
    stall_prev = 1'b0;
  end

  // Input side: every accepted beat goes through the packet model into the scoreboard.
  always @(negedge aclk) begin
    if (aresetn && s_axis_tvalid && s_axis_tready) begin
      beat_t b;
      b = '{last: s_axis_tlast, keep: s_axis_tkeep, strb: s_axis_tstrb, data: s_axis_tdata};
      if (ref_in_pkt) begin
        exp_q.push_back(ref_xform(b, ref_mode, ref_add, ref_xor));
        if (s_axis_tlast) ref_in_pkt = 1'b0;
      end else begin
        exp_q.push_back(ref_xform(b, mode, add_value, xor_key));
        if (!s_axis_tlast) begin
          ref_in_pkt = 1'b1;
          ref_mode   = mode;
          ref_add    = add_value;
          ref_xor    = xor_key;
        end
      end
      acc_count++;
    end
  end

  // Output side: compare transfers in order and require stability while stalled.
  always @(negedge aclk) begin
    if (aresetn) begin
      beat_t cur;
      cur = '{last: m_axis_tlast, keep: m_axis_tkeep, strb: m_axis_tstrb, data: m_axis_tdata};
      if (stall_prev) check("hold_stable", {m_axis_tvalid, cur}, {1'b1, stall_beat});
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat actual=%0h required=none", cur);
        end else begin
          check("scoreboard_beat", cur, exp_q.pop_front());
        end
      end
      stall_prev = m_axis_tvalid && !m_axis_tready;
      stall_beat = cur;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 just after the beat was accepted.
  task automatic send(input logic [DW-1:0] d, input logic l, input logic [NB-1:0] k,
                      input logic [NB-1:0] st, input logic [1:0] md,
                      input logic [DW-1:0] av, input logic [DW-1:0] xk);
    int t;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    s_axis_tkeep  = k;
    s_axis_tstrb  = st;
    mode          = md;
    add_value     = av;
    xor_key       = xk;
    s_axis_tvalid = 1'b1;
    t = 0;
    do begin
      @(negedge aclk);
      t++;
    end while (!s_axis_tready && t < 300);
    if (!s_axis_tready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=%0d cycles required=accept", t);
    end
    @(posedge aclk);
    #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic drain();
    int t;
    m_axis_tready = 1'b1;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(negedge aclk);
      t++;
    end
    check("drain_empty", exp_q.size(), 0);
    step(1);
    check("valid_low_after_drain", m_axis_tvalid, 1'b0);
  endtask

  task automatic check_reset(input string name);
    check(name, {m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tstrb, m_axis_tlast,
                 s_axis_tready, pkt_count, beat_count}, '0);
  endtask

  task automatic release_reset(input string name);
    aresetn = 1'b1;
    check({name, "_ready_before_edge"}, s_axis_tready, 1'b0);
    step(1);
    check({name, "_ready_after_edge"}, s_axis_tready, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int t0;
    int acc0;
    step(3);
    check_reset("reset_outputs");
    release_reset("release1");

    send(32'hAABBCCDD, 1'b1, 4'hF, 4'hF, 2'd0, '0, '0);
    check("pass_out", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {1'b1, 1'b1, 32'hAABBCCDD});
    send(32'h12345678, 1'b1, 4'h1, 4'h1, 2'd1, '0, '0);
    check("rev_out", {m_axis_tdata, m_axis_tkeep}, {32'h78563412, 4'h8});
    send(32'hFFFFFFFF, 1'b1, 4'hF, 4'hF, 2'd2, 32'h1, '0);
    check("add_wrap", m_axis_tdata, 32'h0);

    send(32'h11223344, 1'b0, 4'hF, 4'hF, 2'd3, '0, 32'hFFFF0000);
    check("xor_beat0", m_axis_tdata, 32'hEEDD3344);
    send(32'h55667788, 1'b0, 4'hF, 4'hF, 2'd0, '0, '0);
    check("xor_beat1", m_axis_tdata, 32'hAA997788);
    send(32'h99AABBCC, 1'b1, 4'hF, 4'hF, 2'd0, '0, '0);
    check("xor_beat2", {m_axis_tdata, m_axis_tlast}, {32'h6655BBCC, 1'b1});
    send(32'h01020304, 1'b1, 4'hF, 4'hF, 2'd0, '0, 32'hFFFF0000);
    check("next_pkt_pass", m_axis_tdata, 32'h01020304);

    t0 = $time;
    for (int i = 0; i < 8; i++) send(32'hA0 + i, (i == 7), 4'hF, 4'hF, 2'd2, 32'h10, '0);
    check("throughput_cycles", ($time - t0) / 10, 8);
    drain();

    m_axis_tready = 1'b0;
    acc0 = acc_count;
    fork
      for (int i = 0; i < 4; i++) send(32'hC0DE0000 + i, (i == 3), 4'hF, 4'h3, 2'd3, '0, 32'h0F0F0F0F);
      begin
        step(20);
        check("stall_accepted", acc_count - acc0, 2);
        check("stall_ready_low", s_axis_tready, 1'b0);
        check("stall_valid_high", m_axis_tvalid, 1'b1);
        m_axis_tready = 1'b1;
      end
    join
    drain();
    check("stall_all_accepted", acc_count - acc0, 4);

    fork
      begin
        for (int p = 0; p < 40; p++) begin
          int len;
          len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++) begin
            send($urandom, (b == len - 1), 4'($urandom), 4'($urandom), 2'($urandom),
                 $urandom, $urandom);
            if ($urandom_range(0, 3) == 0) step($urandom_range(1, 3));
          end
        end
        rand_done = 1'b1;
      end
      while (!rand_done) begin
        @(posedge aclk);
        #1;
        m_axis_tready = ($urandom_range(0, 3) != 0);
      end
    join
    drain();

    aresetn = 1'b0;
    step(2);
    release_reset("release2");
    for (int p = 0; p < 5; p++) begin
      send(32'h100 + p, 1'b0, 4'hF, 4'hF, 2'd2, 32'h1, '0);
      send(32'h200 + p, 1'b1, 4'hF, 4'hF, 2'd1, '0, '0);
    end
    drain();
`ifdef AXIS_XFORM_STATS_EN
    check("stats_counts", {pkt_count, beat_count}, {16'd5, 16'd10});
`else
    check("stats_tied_zero", {pkt_count, beat_count}, '0);
`endif

    m_axis_tready = 1'b0;
    send(32'h11111111, 1'b0, 4'hF, 4'hF, 2'd3, '0, 32'hFFFFFFFF);
    step(1);
    aresetn = 1'b0;
    #1;
    check_reset("midpkt_reset_outputs");
    step(2);
    check_reset("midpkt_reset_held");
    release_reset("release3");
    m_axis_tready = 1'b1;
    send(32'hCAFEF00D, 1'b0, 4'hF, 4'hF, 2'd0, '0, 32'hFFFFFFFF);
    check("after_reset_fresh_pkt", {m_axis_tvalid, m_axis_tdata}, {1'b1, 32'hCAFEF00D});
    send(32'h0000FFFF, 1'b1, 4'hF, 4'hF, 2'd3, '0, 32'hFFFFFFFF);
    check("after_reset_captured", m_axis_tdata, 32'h0000FFFF);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
